fifo_mst_ep_bank: RTL and testbench

- Parametrised multi-channel endpoint buffer bank for the FT60x FIFO master.
- Generalises the fixed four-endpoint, 32-bit buffers to NUM_CH channels of configurable data width and depth, held in one shared inferred RAM.
- Adds flush, error pulses, level reporting and optional packet commit/rollback.
- Sits between the bus FSM/datapath (write side) and the arbiter/streaming consumer (read side).

---
 rtl/fifo_mst_pkg.sv | 33 +++
 rtl/fifo_mst_ch_ptr.sv | 127 ++++++++++++
 rtl/fifo_mst_ep_bank.sv | 143 ++++++++++++++
 tb/tb_fifo_mst_ep_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_mst_pkg.sv
// Shared definitions for the FT60x FIFO master endpoint buffer bank.
// Packet commit/rollback support is selected with FIFO_MST_PKT_COMMIT_EN.
package fifo_mst_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? clog2(num_ch) : 1;
    endfunction

    // Pointer width: one extra bit to tell full from empty.
    function automatic int ptr_width(input int unsigned ch_asz);
        return ch_asz + 1;
    endfunction

endpackage

`ifndef FIFO_MST_LVL_SLICE
// Channel i field inside a packed per-channel level vector.
`define FIFO_MST_LVL_SLICE(vec, i, asz) vec[(i)*((asz)+1) +: ((asz)+1)]
`endif

// File: rtl/fifo_mst_ch_ptr.sv
// Per-channel pointer set and status flags for fifo_mst_ep_bank.
// FIFO_MST_PKT_COMMIT_EN adds a staged write pointer with commit/rollback.
module fifo_mst_ch_ptr
    import fifo_mst_pkg::*;
#(
    parameter int CH_ASZ = 10,
    parameter int ALM_TH = 4,
    localparam int PTR_W = ptr_width(CH_ASZ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              wr_last,
    input  logic              wr_abort,
    output logic [CH_ASZ-1:0] wr_addr,
    output logic [CH_ASZ-1:0] rd_addr,
    output logic              full,
    output logic              empty,
    output logic              ld_2_empty,
    output logic              ld_2_full,
    output logic              alm_empty,
    output logic              alm_full,
    output logic [PTR_W-1:0]  level
);

    localparam logic [PTR_W-1:0] DEPTH    = {1'b1, {CH_ASZ{1'b0}}};
    localparam logic [PTR_W-1:0] DEPTH_M1 = DEPTH - PTR_W'(1);
    localparam logic [PTR_W-1:0] ALM_LO   = PTR_W'(ALM_TH);
    localparam logic [PTR_W-1:0] ALM_HI   = DEPTH - PTR_W'(ALM_TH);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] fill_ptr;

`ifdef FIFO_MST_PKT_COMMIT_EN
    logic [PTR_W-1:0] swptr_q, swptr_d;

    // Staged pointer takes the writes; committed pointer follows on wr_last, staged rolls back on abort.
    always_comb begin
        wptr_d  = wptr_q;
        swptr_d = swptr_q;
        rptr_d  = rptr_q;
        if (flush) begin
            wptr_d  = '0;
            swptr_d = '0;
            rptr_d  = '0;
        end else begin
            if (wr_abort) begin
                swptr_d = wptr_q;
            end else if (wr_en) begin
                swptr_d = swptr_q + PTR_W'(1);
                if (wr_last) begin
                    wptr_d = swptr_q + PTR_W'(1);
                end
            end
            if (rd_en) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            swptr_q <= '0;
            rptr_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            swptr_q <= swptr_d;
            rptr_q  <= rptr_d;
        end
    end

    assign fill_ptr = swptr_q;
`else
    logic unused_pkt;
    assign unused_pkt = wr_last ^ wr_abort;

    // Accepted writes and reads advance their pointers; flush zeroes both.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_en) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign fill_ptr = wptr_q;
`endif

    // Flags and level derived from the registered pointers only.
    always_comb begin
        level      = wptr_q - rptr_q;
        empty      = (wptr_q == rptr_q);
        full       = (fill_ptr[PTR_W-1] != rptr_q[PTR_W-1]) &&
                     (fill_ptr[CH_ASZ-1:0] == rptr_q[CH_ASZ-1:0]);
        ld_2_empty = (level == PTR_W'(1));
        ld_2_full  = (level == DEPTH_M1);
        alm_empty  = (level <= ALM_LO);
        alm_full   = (level >= ALM_HI);
        wr_addr    = fill_ptr[CH_ASZ-1:0];
        rd_addr    = rptr_q[CH_ASZ-1:0];
    end

endmodule

// File: rtl/fifo_mst_ep_bank.sv
// Multi-channel endpoint buffer bank: one shared RAM split into NUM_CH
// circular buffers, with flush, level/flag reporting and error pulses.
// FIFO_MST_PKT_COMMIT_EN enables packet commit (wr_last) and rollback (wr_abort).
module fifo_mst_ep_bank
    import fifo_mst_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CH_ASZ = 10,
    parameter int ALM_TH = 4,
    localparam int CH_W  = ch_width(NUM_CH),
    localparam int BE_W  = DATA_W / 8,
    localparam int PTR_W = ptr_width(CH_ASZ)
) (
    input  logic                    fifoClk,
    input  logic                    fifoRstn,
    input  logic                    wr_vld,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [BE_W-1:0]         wr_be,
    input  logic                    wr_last,
    input  logic                    wr_abort,
    output logic                    wr_rdy,
    input  logic                    rd_req,
    input  logic [CH_W-1:0]         rd_ch,
    output logic                    rd_vld,
    output logic [DATA_W-1:0]       rd_data,
    output logic [BE_W-1:0]         rd_be,
    input  logic [NUM_CH-1:0]       ch_flush,
    output logic [NUM_CH-1:0]       fifo_empty,
    output logic [NUM_CH-1:0]       fifo_full,
    output logic [NUM_CH-1:0]       ld_2_empty,
    output logic [NUM_CH-1:0]       ld_2_full,
    output logic [NUM_CH-1:0]       alm_empty,
    output logic [NUM_CH-1:0]       alm_full,
    output logic [NUM_CH*PTR_W-1:0] ch_level,
    output logic                    ovf_err,
    output logic                    unf_err
);

    localparam int MEM_W     = DATA_W + BE_W;
    localparam int MEM_DEPTH = NUM_CH << CH_ASZ;

    logic [MEM_W-1:0]       mem [MEM_DEPTH];
    logic [CH_ASZ-1:0]      wr_addr_a [NUM_CH];
    logic [CH_ASZ-1:0]      rd_addr_a [NUM_CH];
    logic [CH_W+CH_ASZ-1:0] waddr;
    logic [CH_W+CH_ASZ-1:0] raddr;
    logic [NUM_CH-1:0]      wr_sel;
    logic [NUM_CH-1:0]      rd_sel;
    logic [NUM_CH-1:0]      wr_en;
    logic [NUM_CH-1:0]      rd_en;
    logic [NUM_CH-1:0]      last_en;
    logic [NUM_CH-1:0]      abort_en;
    logic                   wr_drop;
    logic                   wr_ok;
    logic                   rd_ok;

    logic                   rd_vld_q, rd_vld_d;
    logic [MEM_W-1:0]       rd_word_q, rd_word_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;

`ifdef FIFO_MST_PKT_COMMIT_EN
    assign wr_drop = wr_abort;
`else
    assign wr_drop = 1'b0;
`endif

    assign wr_rdy = ~fifo_full[wr_ch];

    // Channel decode, acceptance and error detection; flush on a channel masks its traffic and errors.
    always_comb begin
        wr_sel          = '0;
        wr_sel[wr_ch]   = 1'b1;
        rd_sel          = '0;
        rd_sel[rd_ch]   = 1'b1;
        wr_ok    = wr_vld & ~fifo_full[wr_ch] & ~ch_flush[wr_ch] & ~wr_drop;
        rd_ok    = rd_req & ~fifo_empty[rd_ch] & ~ch_flush[rd_ch];
        ovf_d    = wr_vld & fifo_full[wr_ch] & ~ch_flush[wr_ch] & ~wr_drop;
        unf_d    = rd_req & fifo_empty[rd_ch] & ~ch_flush[rd_ch];
        wr_en    = wr_ok ? wr_sel : '0;
        rd_en    = rd_ok ? rd_sel : '0;
        last_en  = wr_last ? wr_sel : '0;
        abort_en = wr_abort ? wr_sel : '0;
        waddr    = {wr_ch, wr_addr_a[wr_ch]};
        raddr    = {rd_ch, rd_addr_a[rd_ch]};
        rd_vld_d = rd_ok;
        rd_word_d = rd_ok ? mem[raddr] : rd_word_q;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fifo_mst_ch_ptr #(
            .CH_ASZ (CH_ASZ),
            .ALM_TH (ALM_TH)
        ) u_ptr (
            .clk        (fifoClk),
            .rst_n      (fifoRstn),
            .flush      (ch_flush[g]),
            .wr_en      (wr_en[g]),
            .rd_en      (rd_en[g]),
            .wr_last    (last_en[g]),
            .wr_abort   (abort_en[g]),
            .wr_addr    (wr_addr_a[g]),
            .rd_addr    (rd_addr_a[g]),
            .full       (fifo_full[g]),
            .empty      (fifo_empty[g]),
            .ld_2_empty (ld_2_empty[g]),
            .ld_2_full  (ld_2_full[g]),
            .alm_empty  (alm_empty[g]),
            .alm_full   (alm_full[g]),
            .level      (`FIFO_MST_LVL_SLICE(ch_level, g, CH_ASZ))
        );
    end

    // Shared RAM write port; data and byte enables are stored together.
    always_ff @(posedge fifoClk) begin
        if (wr_ok) begin
            mem[waddr] <= {wr_be, wr_data};
        end
    end

    // Read-valid, held read word and one-cycle error pulses.
    always_ff @(posedge fifoClk or negedge fifoRstn) begin
        if (!fifoRstn) begin
            rd_vld_q  <= 1'b0;
            rd_word_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_word_q <= rd_word_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign rd_vld           = rd_vld_q;
    assign {rd_be, rd_data} = rd_word_q;
    assign ovf_err          = ovf_q;
    assign unf_err          = unf_q;

endmodule

// File: tb/tb_fifo_mst_ep_bank.sv
// Self-checking bench for fifo_mst_ep_bank against a queue-based channel model.
// Covers the FIFO_MST_PKT_COMMIT_EN behaviour when that macro is defined.
module tb_fifo_mst_ep_bank;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int CH_ASZ = 10;
    localparam int ALM_TH = 4;
    localparam int CH_W   = 2;
    localparam int BE_W   = DATA_W / 8;
    localparam int PW     = CH_ASZ + 1;
    localparam int D      = 1 << CH_ASZ;
    localparam int MW     = DATA_W + BE_W;
`ifdef FIFO_MST_PKT_COMMIT_EN
    localparam bit COMMIT = 1'b1;
`else
    localparam bit COMMIT = 1'b0;
`endif

    logic                    fifoClk = 1'b0;
    logic                    fifoRstn = 1'b1;
    logic                    wr_vld = 1'b0;
    logic [CH_W-1:0]         wr_ch = '0;
    logic [DATA_W-1:0]       wr_data = '0;
    logic [BE_W-1:0]         wr_be = '0;
    logic                    wr_last = 1'b0;
    logic                    wr_abort = 1'b0;
    logic                    wr_rdy;
    logic                    rd_req = 1'b0;
    logic [CH_W-1:0]         rd_ch = '0;
    logic                    rd_vld;
    logic [DATA_W-1:0]       rd_data;
    logic [BE_W-1:0]         rd_be;
    logic [NUM_CH-1:0]       ch_flush = '0;
    logic [NUM_CH-1:0]       fifo_empty, fifo_full, ld_2_empty, ld_2_full, alm_empty, alm_full;
    logic [NUM_CH*PW-1:0]    ch_level;
    logic                    ovf_err, unf_err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model: committed words per channel, staged (uncommitted) words, last read word.
    logic [MW-1:0] q   [NUM_CH][$];
    logic [MW-1:0] stg [NUM_CH][$];
    logic [MW-1:0] last_rd = '0;

    always #5 fifoClk = ~fifoClk;

    fifo_mst_ep_bank #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CH_ASZ (CH_ASZ),
        .ALM_TH (ALM_TH)
    ) dut (
        .fifoClk    (fifoClk),
        .fifoRstn   (fifoRstn),
        .wr_vld     (wr_vld),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .wr_last    (wr_last),
        .wr_abort   (wr_abort),
        .wr_rdy     (wr_rdy),
        .rd_req     (rd_req),
        .rd_ch      (rd_ch),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data),
        .rd_be      (rd_be),
        .ch_flush   (ch_flush),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .ld_2_empty (ld_2_empty),
        .ld_2_full  (ld_2_full),
        .alm_empty  (alm_empty),
        .alm_full   (alm_full),
        .ch_level   (ch_level),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_status();
        logic [NUM_CH-1:0] e_emp, e_ful, e_l2e, e_l2f, e_ae, e_af;
        logic [NUM_CH*PW-1:0] e_lvl;
        int lv, tot;
        for (int i = 0; i < NUM_CH; i++) begin
            lv  = q[i].size();
            tot = lv + stg[i].size();
            e_emp[i] = (lv == 0);
            e_ful[i] = (tot == D);
            e_l2e[i] = (lv == 1);
            e_l2f[i] = (lv == D - 1);
            e_ae[i]  = (lv <= ALM_TH);
            e_af[i]  = (lv >= D - ALM_TH);
            e_lvl[i*PW +: PW] = PW'(lv);
        end
        chk("fifo_empty", 64'(fifo_empty), 64'(e_emp));
        chk("fifo_full",  64'(fifo_full),  64'(e_ful));
        chk("ld_2_empty", 64'(ld_2_empty), 64'(e_l2e));
        chk("ld_2_full",  64'(ld_2_full),  64'(e_l2f));
        chk("alm_empty",  64'(alm_empty),  64'(e_ae));
        chk("alm_full",   64'(alm_full),   64'(e_af));
        chk("ch_level",   64'(ch_level),   64'(e_lvl));
        chk("rd_word",    64'({rd_be, rd_data}), 64'(last_rd));
    endtask

    // Apply the model rules for the current inputs, clock once, compare.
    task automatic step();
        int  wsz, rsz;
        bit  wfl, rfl, abort_now, w_ok, r_ok, e_ovf, e_unf, e_vld;
        wfl       = ch_flush[wr_ch];
        rfl       = ch_flush[rd_ch];
        abort_now = COMMIT && wr_abort;
        wsz       = q[wr_ch].size() + stg[wr_ch].size();
        rsz       = q[rd_ch].size();
        w_ok      = wr_vld && !wfl && !abort_now && (wsz < D);
        e_ovf     = wr_vld && !wfl && !abort_now && (wsz >= D);
        r_ok      = rd_req && !rfl && (rsz > 0);
        e_unf     = rd_req && !rfl && (rsz == 0);
        e_vld     = r_ok;
        if (r_ok) last_rd = q[rd_ch].pop_front();
        if (COMMIT) begin
            if (abort_now && !wfl) begin
                stg[wr_ch].delete();
            end else if (w_ok) begin
                stg[wr_ch].push_back({wr_be, wr_data});
                if (wr_last) begin
                    while (stg[wr_ch].size() > 0) q[wr_ch].push_back(stg[wr_ch].pop_front());
                end
            end
        end else if (w_ok) begin
            q[wr_ch].push_back({wr_be, wr_data});
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_flush[i]) begin
                q[i].delete();
                stg[i].delete();
            end
        end
        @(posedge fifoClk);
        #1;
        chk("rd_vld",  64'(rd_vld),  64'(e_vld));
        chk("ovf_err", 64'(ovf_err), 64'(e_ovf));
        chk("unf_err", 64'(unf_err), 64'(e_unf));
        chk("wr_rdy",  64'(wr_rdy),  64'((q[wr_ch].size() + stg[wr_ch].size()) < D));
        check_status();
    endtask

    task automatic op(input bit wv, input int unsigned wc, input logic [DATA_W-1:0] wd,
                      input bit rr, input int unsigned rc, input logic [NUM_CH-1:0] fl,
                      input bit wl = 1'b0, input bit wa = 1'b0);
        wr_vld   = wv;
        wr_ch    = CH_W'(wc);
        wr_data  = wd;
        wr_be    = BE_W'($urandom);
        wr_last  = wl;
        wr_abort = wa;
        rd_req   = rr;
        rd_ch    = CH_W'(rc);
        ch_flush = fl;
        step();
    endtask

    task automatic idle();
        op(1'b0, 0, '0, 1'b0, 0, '0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            q[i].delete();
            stg[i].delete();
        end
        last_rd = '0;
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge while held.
        #2 fifoRstn = 1'b0;
        #1;
        chk("rst_rd_vld", 64'(rd_vld), 64'(0));
        chk("rst_ovf",    64'(ovf_err), 64'(0));
        chk("rst_unf",    64'(unf_err), 64'(0));
        check_status();
        @(negedge fifoClk);
        @(negedge fifoClk);
        fifoRstn = 1'b1;

        // Fill ch2 to full, then one write too many.
        for (int k = 0; k < D; k++) op(1'b1, 2, $urandom, 1'b0, 0, '0);
        op(1'b1, 2, $urandom, 1'b0, 0, '0);
        idle();

        // Interleaved ch0/ch3 writes, then read back ch3 then ch0.
        for (int k = 1; k <= 16; k++) begin
            op(1'b1, 0, 32'hA5A5_0000 + DATA_W'(k), 1'b0, 0, '0);
            op(1'b1, 3, 32'hA5A5_0000 + DATA_W'(k), 1'b0, 0, '0);
        end
        for (int k = 0; k < 16; k++) op(1'b0, 0, '0, 1'b1, 3, '0);
        for (int k = 0; k < 16; k++) op(1'b0, 0, '0, 1'b1, 0, '0);
        op(1'b0, 0, '0, 1'b1, 0, '0);

        // ch1 full: reads accepted, writes rejected; then half-full steady state.
        for (int k = 0; k < D; k++) op(1'b1, 1, $urandom, 1'b0, 0, '0);
        for (int k = 0; k < 10; k++) op(1'b1, 1, $urandom, 1'b1, 1, '0);
        for (int k = 0; k < D - 10 - D / 2; k++) op(1'b0, 0, '0, 1'b1, 1, '0);
        for (int k = 0; k < 20; k++) op(1'b1, 1, $urandom, 1'b1, 1, '0);

        // Flush ch1 with same-cycle read and write on ch1.
        op(1'b1, 1, $urandom, 1'b1, 1, 4'b0010);
        idle();

        // Wrap ch0 several times with paired write/read.
        op(1'b1, 0, $urandom, 1'b0, 0, '0);
        for (int k = 0; k < 3000; k++) op(1'b1, 0, $urandom, 1'b1, 0, '0);
        op(1'b0, 0, '0, 1'b1, 0, '0);

        // Reset asserted with a read in flight.
        op(1'b1, 3, $urandom, 1'b0, 0, '0);
        op(1'b0, 0, '0, 1'b1, 3, '0);
        idle();
        op(1'b1, 3, $urandom, 1'b1, 2, '0);
        #2 fifoRstn = 1'b0;
        #1;
        model_clear();
        chk("midrst_rd_vld", 64'(rd_vld), 64'(0));
        check_status();
        wr_vld = 1'b0; rd_req = 1'b0; ch_flush = '0;
        @(negedge fifoClk);
        fifoRstn = 1'b1;

`ifdef FIFO_MST_PKT_COMMIT_EN
        // Packet commit and rollback on ch2.
        for (int k = 0; k < 5; k++) op(1'b1, 2, $urandom, 1'b0, 0, '0);
        op(1'b1, 2, $urandom, 1'b0, 0, '0, 1'b1);
        for (int k = 0; k < 3; k++) op(1'b1, 2, $urandom, 1'b0, 0, '0);
        op(1'b1, 2, $urandom, 1'b0, 0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) op(1'b0, 0, '0, 1'b1, 2, '0);
`endif

        // Randomised traffic across all channels.
        for (int k = 0; k < 4000; k++) begin
            op(($urandom % 4) != 0, $urandom % NUM_CH, $urandom,
               ($urandom % 2) != 0, $urandom % NUM_CH,
               (($urandom % 32) == 0) ? NUM_CH'($urandom) : '0,
               ($urandom % 4) == 0, ($urandom % 16) == 0);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
